// File: rtl/map_recovery_ctrl.sv
// Rename-state recovery sequencer: snapshot arch map, restore spec map, rebuild free list by tag scan.
// Latency: COPY one cycle after squash, then N_PHYS_REG/SCAN_WIDTH accepted beats, then one DONE cycle.
// Backpressure: fl_ready=0 holds scan_ptr and the presented push beat stable; busy stays high throughout.
module map_recovery_ctrl #(
  parameter int N_ARCH_REG = 32,
  parameter int N_PHYS_REG = 64,
  parameter int SCAN_WIDTH = 4,
  localparam int PHYS_BITS = $clog2(N_PHYS_REG)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash_valid,
  input  logic [N_ARCH_REG*PHYS_BITS-1:0]  arch_maptable,
  input  logic                             fl_ready,
  output logic                             busy,
  output logic                             mt_restore,
  output logic [N_ARCH_REG*PHYS_BITS-1:0]  mt_restore_map,
  output logic                             fl_clear,
  output logic [SCAN_WIDTH-1:0]            fl_push_valid,
  output logic [SCAN_WIDTH*PHYS_BITS-1:0]  fl_push_tag,
  output logic                             done
);

  localparam int MAP_BITS = N_ARCH_REG * PHYS_BITS;
  localparam logic [PHYS_BITS-1:0] LAST_PTR = PHYS_BITS'(N_PHYS_REG - SCAN_WIDTH);
  localparam logic [PHYS_BITS-1:0] PTR_STEP = PHYS_BITS'(SCAN_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [MAP_BITS-1:0]  snapshot_q, snapshot_d;
  logic [PHYS_BITS-1:0] scan_ptr_q, scan_ptr_d;
  logic                 busy_q, busy_d;
  logic                 mt_restore_q, mt_restore_d;
  logic                 fl_clear_q, fl_clear_d;
  logic                 done_q, done_d;

  // Next-state logic; control outputs are derived from the next state so they register alongside it.
  always_comb begin
    state_d    = state_q;
    snapshot_d = snapshot_q;
    scan_ptr_d = scan_ptr_q;
    case (state_q)
      IDLE: begin
        if (squash_valid) begin
          state_d    = COPY;
          snapshot_d = arch_maptable;
        end
      end
      COPY: begin
        scan_ptr_d = '0;
        state_d    = SCAN;
      end
      SCAN: begin
        if (fl_ready) begin
          scan_ptr_d = scan_ptr_q + PTR_STEP;
          if (scan_ptr_q == LAST_PTR) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d       = (state_d != IDLE);
    mt_restore_d = (state_d == COPY);
    fl_clear_d   = (state_d == COPY);
    done_d       = (state_d == DONE);
  end

  // State and registered outputs; synchronous reset aborts any recovery without a done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      snapshot_q   <= '0;
      scan_ptr_q   <= '0;
      busy_q       <= 1'b0;
      mt_restore_q <= 1'b0;
      fl_clear_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      snapshot_q   <= snapshot_d;
      scan_ptr_q   <= scan_ptr_d;
      busy_q       <= busy_d;
      mt_restore_q <= mt_restore_d;
      fl_clear_q   <= fl_clear_d;
      done_q       <= done_d;
    end
  end

  // Push beat: a tag is free iff no snapshot entry names it; duplicates in the snapshot are harmless.
  always_comb begin
    logic [PHYS_BITS-1:0] tag;
    logic                 hit;
    fl_push_valid = '0;
    fl_push_tag   = '0;
    tag           = '0;
    hit           = 1'b0;
    if (state_q == SCAN) begin
      for (int k = 0; k < SCAN_WIDTH; k++) begin
        tag = scan_ptr_q + PHYS_BITS'(k);
        hit = 1'b0;
        for (int r = 0; r < N_ARCH_REG; r++) begin
          if (snapshot_q[r*PHYS_BITS +: PHYS_BITS] == tag) begin
            hit = 1'b1;
          end
        end
        fl_push_valid[k]                     = ~hit;
        fl_push_tag[k*PHYS_BITS +: PHYS_BITS] = tag;
      end
    end
  end

  assign busy           = busy_q;
  assign mt_restore     = mt_restore_q;
  assign mt_restore_map = snapshot_q;
  assign fl_clear       = fl_clear_q;
  assign done           = done_q;

endmodule

// File: tb/tb_map_recovery_ctrl.sv
module tb_map_recovery_ctrl;

  localparam int NA = 32;
  localparam int NP = 64;
  localparam int SW = 4;
  localparam int PB = 6;
  localparam int NB = NP / SW;

  logic               clock = 1'b0;
  logic               reset;
  logic               squash_valid;
  logic [NA*PB-1:0]   arch_maptable;
  logic               fl_ready;
  logic               busy;
  logic               mt_restore;
  logic [NA*PB-1:0]   mt_restore_map;
  logic               fl_clear;
  logic [SW-1:0]      fl_push_valid;
  logic [SW*PB-1:0]   fl_push_tag;
  logic               done;

  map_recovery_ctrl #(.N_ARCH_REG(NA), .N_PHYS_REG(NP), .SCAN_WIDTH(SW)) dut (
    .clock(clock), .reset(reset), .squash_valid(squash_valid), .arch_maptable(arch_maptable),
    .fl_ready(fl_ready), .busy(busy), .mt_restore(mt_restore), .mt_restore_map(mt_restore_map),
    .fl_clear(fl_clear), .fl_push_valid(fl_push_valid), .fl_push_tag(fl_push_tag), .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard queues filled by stimulus, drained by the monitor.
  logic [NA*PB-1:0] q_map[$];
  logic [SW-1:0]    q_mask[$];
  int               q_done[$];
  int               q_cnt[$];

  task automatic chk(input string nm, input logic [NA*PB-1:0] act, input logic [NA*PB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [NA*PB-1:0] identity_map();
    logic [NA*PB-1:0] m;
    for (int r = 0; r < NA; r++) m[r*PB +: PB] = PB'(r);
    return m;
  endfunction

  function automatic logic [NA*PB-1:0] random_map(input int max_tag);
    logic [NA*PB-1:0] m;
    for (int r = 0; r < NA; r++) m[r*PB +: PB] = PB'($urandom_range(0, max_tag));
    return m;
  endfunction

  // Reference model: free tags are those absent from the snapshot, scanned in SW-wide groups.
  task automatic expect_recovery(input logic [NA*PB-1:0] snap, input int done_cyc);
    bit            mapped[NP];
    logic [SW-1:0] mask;
    int            cnt;
    cnt = 0;
    for (int t = 0; t < NP; t++) mapped[t] = 1'b0;
    for (int r = 0; r < NA; r++) mapped[int'(snap[r*PB +: PB])] = 1'b1;
    q_map.push_back(snap);
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < SW; k++) begin
        mask[k] = !mapped[b*SW + k];
        cnt += int'(mask[k]);
      end
      q_mask.push_back(mask);
    end
    q_done.push_back(done_cyc);
    q_cnt.push_back(cnt);
  endtask

  // Monitor: samples on the falling edge and checks restore, each scan beat and the done pulse.
  int beat_idx = 0;
  int pushed = 0;
  always @(negedge clock) begin
    logic [SW*PB-1:0] exp_tag;
    if (!reset) begin
      if (mt_restore) begin
        chk("copy_clear", {fl_clear, busy}, 2'b11);
        if (q_map.size() == 0) fail_now("unexpected_restore");
        else chk("restore_map", mt_restore_map, q_map.pop_front());
        beat_idx = 0;
        pushed = 0;
      end else if (done) begin
        chk("done_valid_zero", fl_push_valid, '0);
        if (q_done.size() == 0) fail_now("unexpected_done");
        else begin
          chk("done_cycle", cyc, q_done.pop_front());
          chk("pushed_count", pushed, q_cnt.pop_front());
        end
      end else if (busy) begin
        if (q_mask.size() == 0) fail_now("unexpected_beat");
        else begin
          chk("beat_mask", fl_push_valid, q_mask[0]);
          for (int k = 0; k < SW; k++) exp_tag[k*PB +: PB] = PB'(beat_idx*SW + k);
          chk("beat_tag", fl_push_tag, exp_tag);
          if (fl_ready) begin
            void'(q_mask.pop_front());
            pushed += $countones(fl_push_valid);
            beat_idx++;
          end
        end
      end
    end
  end

  // mode 0: ready always; 1: random ready; 2: three stall cycles mid-scan. abort_beat>=0 resets there.
  task automatic run_recovery(input int mode, input logic [NA*PB-1:0] map, input int abort_beat);
    bit rdy[200];
    int acc, i, c, done_c, last_c;
    for (int j = 0; j < 200; j++) begin
      if (mode == 1 && j < 150) rdy[j] = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && j >= 5 && j <= 7) rdy[j] = 1'b0;
      else rdy[j] = 1'b1;
    end
    acc = 0;
    i = 0;
    while (acc < NB) begin
      if (rdy[i]) acc++;
      i++;
    end
    @(posedge clock); #1;
    c = cyc;
    squash_valid  = 1'b1;
    arch_maptable = map;
    fl_ready      = 1'($urandom);
    done_c = c + 2 + i;
    expect_recovery(map, done_c);
    last_c = (abort_beat >= 0) ? c + 2 + abort_beat : done_c;
    while (cyc < last_c) begin
      @(posedge clock); #1;
      squash_valid  = 1'($urandom);
      arch_maptable = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      fl_ready      = (cyc >= c + 2) ? rdy[cyc - c - 2] : 1'($urandom);
      if (abort_beat >= 0 && cyc == last_c) reset = 1'b1;
    end
    @(posedge clock); #1;
    squash_valid = 1'b0;
    if (abort_beat >= 0) begin
      reset = 1'b0;
      chk("abort_ctrl_zero", {busy, mt_restore, fl_clear, done, fl_push_valid, fl_push_tag}, '0);
      chk("abort_map_zero", mt_restore_map, '0);
      q_mask.delete();
      q_done.delete();
      q_cnt.delete();
    end else begin
      chk("busy_after_done", busy, 1'b0);
    end
    repeat (2) @(posedge clock);
  endtask

  initial begin
    logic [NA*PB-1:0] m;
    reset = 1'b1;
    squash_valid = 1'b0;
    fl_ready = 1'b0;
    arch_maptable = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctrl_zero", {busy, mt_restore, fl_clear, done, fl_push_valid, fl_push_tag}, '0);
    chk("reset_map_zero", mt_restore_map, '0);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    run_recovery(0, identity_map(), -1);
    m = identity_map();
    m[5*PB +: PB] = PB'(40);
    run_recovery(0, m, -1);
    run_recovery(2, identity_map(), -1);
    run_recovery(0, random_map(NP - 1), 6);
    run_recovery(0, identity_map(), -1);
    run_recovery(1, random_map(7), -1);
    for (int n = 0; n < 6; n++) run_recovery(n % 3, random_map(NP - 1), -1);

    repeat (3) @(posedge clock);
    chk("queues_drained", q_map.size() + q_mask.size() + q_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
